// File: rtl/udl_pkg.sv
// Shared constants and types for the UDL counter scheduler.
// State encoding is kept as plain 2-bit constants so older netlists can match it.
package udl_pkg;

  localparam int unsigned IdW = 1;

  typedef logic [1:0]     state_t;
  typedef logic [IdW-1:0] req_id_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StLoad = 2'd1;
  localparam state_t StRun  = 2'd2;
  localparam state_t StDone = 2'd3;

  localparam req_id_t Req0 = 1'b0;
  localparam req_id_t Req1 = 1'b1;

endpackage

// File: rtl/udl_counter_core.sv
// Up/down/load counter with modular wrap; load has priority over enable.
module udl_counter_core #(
  parameter int unsigned BITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            en,
  input  logic            up,
  input  logic [BITS-1:0] pi,
  output logic [BITS-1:0] q
);

  localparam logic [BITS-1:0] One = BITS'(1);

  logic [BITS-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = pi;
    end else if (en) begin
      q_d = up ? (q_q + One) : (q_q - One);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/udl_cnt_sched.sv
// Round-robin scheduler sharing one UDL counter between two requesters.
// Accepted jobs are loaded, counted to their end value, then signalled with a done pulse.
module udl_cnt_sched
  import udl_pkg::*;
#(
  parameter int unsigned BITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [BITS-1:0] req0_start,
  input  logic [BITS-1:0] req0_end,
  input  logic            req0_up,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [BITS-1:0] req1_start,
  input  logic [BITS-1:0] req1_end,
  input  logic            req1_up,
  output logic            done0,
  output logic            done1,
  output logic            busy,
  output logic            owner,
  output logic [BITS-1:0] q
);

  state_t          state_d, state_q;
  req_id_t         owner_d, owner_q;
  req_id_t         last_grant_d, last_grant_q;
  logic [BITS-1:0] job_start_d, job_start_q;
  logic [BITS-1:0] job_end_d, job_end_q;
  logic            job_up_d, job_up_q;

  req_id_t         grant_id;
  logic            xfer;
  logic            cnt_load;
  logic            cnt_en;
  logic [BITS-1:0] cnt_q;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant_id = Req0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_q;
    end else if (req1_valid) begin
      grant_id = Req1;
    end
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst && (state_q == StIdle)) begin
      req0_ready = req0_valid && (grant_id == Req0);
      req1_ready = req1_valid && (grant_id == Req1);
    end
  end

  assign xfer = req0_ready || req1_ready;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    job_start_d  = job_start_q;
    job_end_d    = job_end_q;
    job_up_d     = job_up_q;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          owner_d = grant_id;
          state_d = StLoad;
          if (grant_id == Req1) begin
            job_start_d = req1_start;
            job_end_d   = req1_end;
            job_up_d    = req1_up;
          end else begin
            job_start_d = req0_start;
            job_end_d   = req0_end;
            job_up_d    = req0_up;
          end
        end
      end
      StLoad: begin
        state_d = StRun;
      end
      StRun: begin
        if (cnt_q == job_end_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        last_grant_d = owner_q;
        state_d      = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= Req0;
      last_grant_q <= Req1;
      job_start_q  <= '0;
      job_end_q    <= '0;
      job_up_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      job_start_q  <= job_start_d;
      job_end_q    <= job_end_d;
      job_up_q     <= job_up_d;
    end
  end

  assign cnt_load = (state_q == StLoad);
  assign cnt_en   = (state_q == StRun) && (cnt_q != job_end_q);

  udl_counter_core #(
    .BITS (BITS)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .up   (job_up_q),
    .pi   (job_start_q),
    .q    (cnt_q)
  );

  assign q     = cnt_q;
  assign busy  = (state_q != StIdle);
  assign owner = owner_q;
  assign done0 = (state_q == StDone) && (owner_q == Req0);
  assign done1 = (state_q == StDone) && (owner_q == Req1);

endmodule

// File: tb/tb_udl_cnt_sched.sv
// Scoreboard bench for udl_cnt_sched: expected q values and done pulses are queued at acceptance.
module tb_udl_cnt_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_start = '0, req0_end = '0, req1_start = '0, req1_end = '0;
  logic       req0_up = 1'b0, req1_up = 1'b0;
  logic       done0, done1, busy, owner;
  logic [3:0] q;

  udl_cnt_sched #(
    .BITS (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_start (req0_start),
    .req0_end   (req0_end),
    .req0_up    (req0_up),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_start (req1_start),
    .req1_end   (req1_end),
    .req1_up    (req1_up),
    .done0      (done0),
    .done1      (done1),
    .busy       (busy),
    .owner      (owner),
    .q          (q)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } qexp_t;

  typedef struct {
    int         cyc;
    int         id;
    logic [3:0] endv;
  } dexp_t;

  qexp_t qq[$];
  dexp_t dq[$];
  int    accq[$];
  int    acc_cyc[$];
  int    cyc = 0;
  int    last_done0_cyc = -1;
  int    n_checks = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sampled on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      qexp_t e;
      dexp_t d;
      chk("done_excl", int'(done0 && done1), 0);
      if (busy) chk("rdy_busy", int'({req1_ready, req0_ready}), 0);

      if (req0_valid && req0_ready || req1_valid && req1_ready) begin
        int         id;
        logic [3:0] s, en, k, v;
        logic       u;
        chk("rdy_one", int'(req0_ready && req1_ready), 0);
        id = req1_ready ? 1 : 0;
        s  = id ? req1_start : req0_start;
        en = id ? req1_end : req0_end;
        u  = id ? req1_up : req0_up;
        k  = u ? (en - s) : (s - en);
        v  = s;
        for (int j = 0; j <= int'(k); j++) begin
          e.cyc = cyc + 2 + j;
          e.val = v;
          qq.push_back(e);
          v = u ? v + 4'd1 : v - 4'd1;
        end
        d.cyc  = cyc + 3 + int'(k);
        d.id   = id;
        d.endv = en;
        dq.push_back(d);
        accq.push_back(id);
        acc_cyc.push_back(cyc);
      end

      if (qq.size() > 0 && qq[0].cyc <= cyc) begin
        e = qq.pop_front();
        chk("q_seq_cyc", cyc, e.cyc);
        chk("q_seq", int'(q), int'(e.val));
      end

      if (done0 || done1) begin
        if (dq.size() == 0) begin
          chk("done_unexpected", int'({done1, done0}), 0);
        end else begin
          d = dq.pop_front();
          chk("done_cyc", cyc, d.cyc);
          chk("done_id", done1 ? 1 : 0, d.id);
          chk("owner", int'(owner), d.id);
          chk("q_final", int'(q), int'(d.endv));
          if (done0) last_done0_cyc = cyc;
        end
      end else if (dq.size() > 0 && dq[0].cyc < cyc) begin
        chk("done_missing", cyc, dq[0].cyc);
        void'(dq.pop_front());
      end
    end
  end

  // Call just after a rising edge; returns just after a rising edge.
  task automatic send(input int id, input logic [3:0] s, input logic [3:0] e, input logic u,
                      input bit keep);
    bit ok = 1'b0;
    if (id == 0) begin
      req0_valid = 1'b1; req0_start = s; req0_end = e; req0_up = u;
    end else begin
      req1_valid = 1'b1; req1_start = s; req1_end = e; req1_up = u;
    end
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (id == 0) ? req0_ready : req1_ready;
    end
    chk("accepted", int'(ok), 1);
    @(posedge clk); #1;
    if (!keep) begin
      if (id == 0) req0_valid = 1'b0;
      else         req1_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (dq.size() > 0 || qq.size() > 0); i++) begin
      @(negedge clk); #1;
    end
    chk("drain_timeout", dq.size() + qq.size(), 0);
    @(negedge clk); #1;
    chk("busy_after", int'(busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    qq.delete();
    dq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset phase with both requesters asking: no ready may appear.
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rdy_in_rst", int'({req1_ready, req0_ready}), 0);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_q", int'(q), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_done", int'({done1, done0}), 0);
    @(posedge clk); #1;

    // Reset in the middle of a running job: job is dropped without done.
    send(0, 4'd3, 4'd7, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrun_busy", int'(busy), 1);
    do_reset();
    @(negedge clk); #1;
    chk("midrst_q", int'(q), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_owner", int'(owner), 0);
    for (int i = 0; i < 12; i++) @(posedge clk);
    #1;

    // Single up job, down job with wrap, up wrap, zero-distance job.
    send(0, 4'd3, 4'd7, 1'b1, 1'b0);
    drain();
    send(1, 4'd2, 4'd14, 1'b0, 1'b0);
    drain();
    chk("owner_hold", int'(owner), 1);
    send(0, 4'd14, 4'd1, 1'b1, 1'b0);
    drain();
    send(0, 4'd5, 4'd5, 1'b1, 1'b0);
    drain();
    chk("q_hold", int'(q), 5);

    // Contention from reset: grants must alternate 0,1,0,1.
    do_reset();
    accq.delete();
    fork
      begin
        send(0, 4'd1, 4'd3, 1'b1, 1'b1);
        send(0, 4'd8, 4'd6, 1'b0, 1'b0);
      end
      begin
        send(1, 4'd10, 4'd12, 1'b1, 1'b1);
        send(1, 4'd0, 4'd15, 1'b0, 1'b0);
      end
    join
    drain();
    chk("order_n", accq.size(), 4);
    if (accq.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("order", accq[i], i % 2);
    end

    // Back-to-back: req1 waits behind req0 and is granted right after done0.
    accq.delete();
    acc_cyc.delete();
    fork
      send(0, 4'd3, 4'd7, 1'b1, 1'b0);
      begin
        @(posedge clk); #1;
        send(1, 4'd9, 4'd11, 1'b1, 1'b0);
      end
    join
    drain();
    chk("b2b_n", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2) begin
      chk("b2b_first", accq[0], 0);
      chk("b2b_gap", acc_cyc[1], last_done0_cyc + 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
